dcu_bit_window: RTL and testbench
=================================

Name: dcu_bit_window

Overview:
Bitstream front end of the DCU. It sits directly upstream of the code-length/Huffman decode stage. It accepts the compressed stream one byte at a time over a valid/ready handshake and holds the bits in an LSB-first shift buffer. It presents an 8-bit code window plus a 4-bit-compatible consume interface: the downstream decoder peeks at the window, resolves a symbol of len bits, and then retires exactly that many bits. It also supports byte alignment for stored blocks, and tracks errors and total bits consumed.

Parameters:
BUF_W, 24, shift-buffer depth in bits; must be at least 16.
CNT_W, 5, width of the bit-count register; must satisfy 2^CNT_W > BUF_W.

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
blk_clr  in  1  synchronous clear of buffer, counters and error
in_vld  in  1  input byte valid
in_byte  in  8  input byte; bit0 is the first stream bit
in_rdy  out  1  buffer can accept a byte this cycle
cons_en  in  1  retire cons_len bits this cycle
cons_len  in  4  bits to retire, 0..8; 0 is a no-op
align_en  in  1  discard bits up to the next byte boundary
peek_lsb  out  8  next 8 buffered bits, bit0 = next stream bit
code  out  8  bit-reversed peek_lsb (first stream bit in bit7), drives downstream code input
avail  out  CNT_W  number of valid buffered bits
win_vld  out  1  avail >= 8
tot_bits  out  16  total bits retired since reset/clear, wraps mod 2^16
err  out  1  sticky protocol-error flag

Behaviour:
- State: buf[BUF_W-1:0], cnt, pos[2:0] (tot_bits mod 8), tot_bits, err.
- Reset (async) and blk_clr (sync, highest priority) set all state to zero. Outputs after reset/clear:
  - in_rdy=1, avail=0, win_vld=0, peek_lsb=0, code=0, tot_bits=0, err=0.
- Output timing:
  - peek_lsb = buf[7:0], with bits at or above cnt forced to 0.
  - code = bit-reverse of peek_lsb.
  - peek_lsb, code, avail, win_vld and in_rdy are combinational from registers only, with no input-to-output paths.
- in_rdy = (cnt <= BUF_W-8). It depends on current cnt only and does not credit a same-cycle consume.
- Byte accept on in_vld & in_rdy. The new byte is appended at bit position cnt-k, where k is the number of bits removed in the same cycle.
- Consume: k = cons_len when cons_en & cons_len != 0 & cons_len <= cnt & cons_len <= 8.
  - buf shifts right by k; cnt -= k; tot_bits += k; pos += k (mod 8).
- Illegal consume (cons_len > cnt, or cons_len > 8, with cons_en=1):
  - No bits are removed and err is set. A byte arriving in the same cycle is still accepted.
- Align: k = (8-pos) mod 8.
  - If k > cnt, err is set and nothing is removed.
  - When pos=0, align is a legal no-op.
- align_en & cons_en in the same cycle: align executes, the consume is ignored, and err is set.
- Simultaneous byte accept and consume: cnt_next = cnt - k + 8.
  - BUF_W >= 16 guarantees no overflow given the in_rdy rule.
- err is cleared only by reset or blk_clr. Operation continues normally after err is set.
- Latency:
  - A byte accepted in cycle N is visible in peek/avail in cycle N+1.
  - A consume in cycle N updates the window in cycle N+1.
- Throughput: one byte in and up to 8 bits out per cycle, sustained.
- Reset mid-stream discards all buffered bits. No partial byte survives.

Test Plan:
- Reset, then drive in_byte=0xB5 once -> next cycle avail=8, win_vld=1, peek_lsb=0xB5, code=0xAD, in_rdy=1.
- From that state, cons_en=1 and cons_len=3 -> avail=5, peek_lsb=0x16, win_vld=0, tot_bits=3; then align_en -> avail=0, tot_bits=8, err=0.
- Stream 0x12, 0x34, 0x56 back-to-back with no consume -> avail=24, in_rdy=0 after the third byte; a fourth byte held with in_vld is not accepted until cons_len=8 retires bits, after which it is accepted and avail=24.
- With avail=4, cons_len=5 -> err=1, avail stays 4, tot_bits unchanged; a later blk_clr -> err=0, avail=0.
- With avail=8, in_vld=1 (byte 0xFF) together with cons_len=8 on input 0x00 -> next cycle avail=8, peek_lsb=0xFF.
- Assert rst_n low mid-stream with avail=13 -> all outputs return to reset values immediately; the first byte after release appears intact at peek_lsb.

Source files
------------

// File: rtl/dcu_bit_window.sv
// LSB-first bit window in front of the code-length/Huffman decoder: bytes in, 0..8 bits out per cycle,
// with byte alignment, a bits-retired counter and a sticky protocol-error flag.
module dcu_bit_window #(
   parameter int BUF_W = 24,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             blk_clr,
   input  logic             in_vld,
   input  logic [7:0]       in_byte,
   output logic             in_rdy,
   input  logic             cons_en,
   input  logic [3:0]       cons_len,
   input  logic             align_en,
   output logic [7:0]       peek_lsb,
   output logic [7:0]       code,
   output logic [CNT_W-1:0] avail,
   output logic             win_vld,
   output logic [15:0]      tot_bits,
   output logic             err
);

   // Handshake: a byte transfers on a rising edge where in_vld & in_rdy; in_rdy depends on stored state only.
   logic [BUF_W-1:0] bit_buf;
   logic [CNT_W-1:0] cnt;
   logic [15:0]      tot_q;
   logic             err_q;

   logic [3:0]       rem_k;
   logic [2:0]       align_k;
   logic             set_err;
   logic             accept;
   logic [CNT_W-1:0] cnt_rem;
   logic [CNT_W-1:0] cnt_nxt;
   logic [BUF_W-1:0] buf_nxt;

   assign in_rdy  = (cnt <= CNT_W'(BUF_W - 8));
   assign accept  = in_vld & in_rdy;
   assign align_k = 3'd0 - tot_q[2:0];

   always_comb begin
      rem_k   = 4'd0;
      set_err = 1'b0;
      if (align_en) begin
         // align wins over a same-cycle consume, which is flagged as a protocol error
         if (cons_en) set_err = 1'b1;
         if (CNT_W'(align_k) > cnt) set_err = 1'b1;
         else                       rem_k   = {1'b0, align_k};
      end else if (cons_en && cons_len != 4'd0) begin
         if (cons_len > 4'd8 || CNT_W'(cons_len) > cnt) set_err = 1'b1;
         else                                           rem_k   = cons_len;
      end
   end

   // Buffer bits at or above cnt are kept zero, so the new byte can simply be OR-ed in behind the survivors.
   always_comb begin
      cnt_rem = cnt - CNT_W'(rem_k);
      buf_nxt = bit_buf >> rem_k;
      cnt_nxt = cnt_rem;
      if (accept) begin
         buf_nxt = buf_nxt | (BUF_W'(in_byte) << cnt_rem);
         cnt_nxt = cnt_rem + CNT_W'(8);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_buf <= '0;
         cnt     <= '0;
         tot_q   <= '0;
         err_q   <= 1'b0;
      end else if (blk_clr) begin
         bit_buf <= '0;
         cnt     <= '0;
         tot_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         bit_buf <= buf_nxt;
         cnt     <= cnt_nxt;
         tot_q   <= tot_q + 16'(rem_k);
         if (set_err) err_q <= 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         peek_lsb[i] = bit_buf[i] & (CNT_W'(i) < cnt);
         code[7-i]   = bit_buf[i] & (CNT_W'(i) < cnt);
      end
   end

   assign avail    = cnt;
   assign win_vld  = (cnt >= CNT_W'(8));
   assign tot_bits = tot_q;
   assign err      = err_q;

endmodule

// File: tb/tb_dcu_bit_window.sv
// Bench for dcu_bit_window: directed scenarios with literal expectations, then random traffic
// checked every cycle against a bit-queue model of the stream.
module tb_dcu_bit_window;
   localparam int BUF_W = 24;
   localparam int CNT_W = 5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             blk_clr = 1'b0;
   logic             in_vld = 1'b0;
   logic [7:0]       in_byte = 8'h00;
   logic             in_rdy;
   logic             cons_en = 1'b0;
   logic [3:0]       cons_len = 4'd0;
   logic             align_en = 1'b0;
   logic [7:0]       peek_lsb;
   logic [7:0]       code;
   logic [CNT_W-1:0] avail;
   logic             win_vld;
   logic [15:0]      tot_bits;
   logic             err;

   int n_chk = 0;
   int n_fail = 0;

   dcu_bit_window #(.BUF_W(BUF_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .blk_clr(blk_clr),
      .in_vld(in_vld), .in_byte(in_byte), .in_rdy(in_rdy),
      .cons_en(cons_en), .cons_len(cons_len), .align_en(align_en),
      .peek_lsb(peek_lsb), .code(code), .avail(avail), .win_vld(win_vld),
      .tot_bits(tot_bits), .err(err)
   );

   // clock / reset
   always #5 clk = ~clk;

   // ---------------- behavioural model: the stream as a queue of bits ----------------
   bit m_q[$];
   int m_tot;
   bit m_err;
   int m_n, m_pos, m_k, m_al;
   bit m_acc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || blk_clr) begin
         m_q.delete();
         m_tot = 0;
         m_err = 0;
      end else begin
         m_n   = m_q.size();
         m_pos = m_tot % 8;
         m_al  = (8 - m_pos) % 8;
         m_k   = 0;
         m_acc = in_vld && (m_n <= BUF_W - 8);
         if (align_en) begin
            if (cons_en) m_err = 1;
            if (m_al > m_n) m_err = 1;
            else m_k = m_al;
         end else if (cons_en && cons_len != 0) begin
            if (cons_len > 8 || int'(cons_len) > m_n) m_err = 1;
            else m_k = cons_len;
         end
         repeat (m_k) void'(m_q.pop_front());
         m_tot = (m_tot + m_k) % 65536;
         if (m_acc)
            for (int i = 0; i < 8; i++) m_q.push_back(in_byte[i]);
      end
   end

   function automatic logic [7:0] model_peek();
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++)
         if (i < m_q.size()) p[i] = m_q[i];
      return p;
   endfunction

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[7-i] = v[i];
      return r;
   endfunction

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // compare process: outputs are register-only, so mid-cycle (negedge) is a stable sample point
   always @(negedge clk) begin
      if (rst_n) begin
         chk("m_peek",  32'(peek_lsb), 32'(model_peek()));
         chk("m_code",  32'(code),     32'(rev8(model_peek())));
         chk("m_avail", 32'(avail),    32'(m_q.size()));
         chk("m_win",   32'(win_vld),  32'(m_q.size() >= 8));
         chk("m_rdy",   32'(in_rdy),   32'(m_q.size() <= BUF_W - 8));
         chk("m_tot",   32'(tot_bits), 32'(m_tot));
         chk("m_err",   32'(err),      32'(m_err));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input logic v, input logic [7:0] b, input logic ce, input logic [3:0] cl,
                      input logic ae, input logic clr);
      in_vld = v; in_byte = b; cons_en = ce; cons_len = cl; align_en = ae; blk_clr = clr;
      @(negedge clk);
      in_vld = 0; in_byte = 8'h00; cons_en = 0; cons_len = 4'd0; align_en = 0; blk_clr = 0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rdy"},   32'(in_rdy),   32'd1);
      chk({tag, "_avail"}, 32'(avail),    32'd0);
      chk({tag, "_win"},   32'(win_vld),  32'd0);
      chk({tag, "_peek"},  32'(peek_lsb), 32'd0);
      chk({tag, "_code"},  32'(code),     32'd0);
      chk({tag, "_tot"},   32'(tot_bits), 32'd0);
      chk({tag, "_err"},   32'(err),      32'd0);
   endtask

   initial begin
      #1;
      chk_reset_vals("rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // first byte and its window
      cyc(1, 8'hB5, 0, 0, 0, 0);
      chk("b5_avail", 32'(avail), 32'd8);
      chk("b5_win",   32'(win_vld), 32'd1);
      chk("b5_peek",  32'(peek_lsb), 32'hB5);
      chk("b5_code",  32'(code), 32'hAD);
      chk("b5_rdy",   32'(in_rdy), 32'd1);
      cyc(0, 0, 1, 4'd3, 0, 0);
      chk("c3_avail", 32'(avail), 32'd5);
      chk("c3_peek",  32'(peek_lsb), 32'h16);
      chk("c3_win",   32'(win_vld), 32'd0);
      chk("c3_tot",   32'(tot_bits), 32'd3);
      cyc(0, 0, 0, 0, 1, 0);
      chk("al_avail", 32'(avail), 32'd0);
      chk("al_tot",   32'(tot_bits), 32'd8);
      chk("al_err",   32'(err), 32'd0);

      // fill to the top, then backpressure
      cyc(1, 8'h12, 0, 0, 0, 0);
      cyc(1, 8'h34, 0, 0, 0, 0);
      cyc(1, 8'h56, 0, 0, 0, 0);
      chk("full_avail", 32'(avail), 32'd24);
      chk("full_rdy",   32'(in_rdy), 32'd0);
      cyc(1, 8'h78, 0, 0, 0, 0);
      chk("held_avail", 32'(avail), 32'd24);
      cyc(1, 8'h78, 1, 4'd8, 0, 0);
      chk("drain_avail", 32'(avail), 32'd16);
      chk("drain_peek",  32'(peek_lsb), 32'h34);
      cyc(1, 8'h78, 0, 0, 0, 0);
      chk("refill_avail", 32'(avail), 32'd24);
      chk("refill_peek",  32'(peek_lsb), 32'h34);

      // illegal consume, then clear
      cyc(0, 0, 0, 0, 0, 1);
      cyc(1, 8'h0F, 0, 0, 0, 0);
      cyc(0, 0, 1, 4'd4, 0, 0);
      chk("c4_avail", 32'(avail), 32'd4);
      cyc(0, 0, 1, 4'd5, 0, 0);
      chk("ill_err",   32'(err), 32'd1);
      chk("ill_avail", 32'(avail), 32'd4);
      chk("ill_tot",   32'(tot_bits), 32'd4);
      cyc(0, 0, 0, 0, 0, 1);
      chk("clr_err",   32'(err), 32'd0);
      chk("clr_avail", 32'(avail), 32'd0);

      // byte in and 8 bits out in the same cycle
      cyc(1, 8'hAA, 0, 0, 0, 0);
      cyc(1, 8'hFF, 1, 4'd8, 0, 0);
      chk("sim_avail", 32'(avail), 32'd8);
      chk("sim_peek",  32'(peek_lsb), 32'hFF);

      // reset mid-stream with 13 bits buffered
      cyc(1, 8'h11, 0, 0, 0, 0);
      cyc(0, 0, 1, 4'd3, 0, 0);
      chk("pre_rst_avail", 32'(avail), 32'd13);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cyc(1, 8'hC3, 0, 0, 0, 0);
      chk("post_rst_peek",  32'(peek_lsb), 32'hC3);
      chk("post_rst_avail", 32'(avail), 32'd8);

      // randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         in_vld   = ($urandom_range(0, 9) < 7);
         in_byte  = 8'($urandom);
         cons_en  = ($urandom_range(0, 1) == 1);
         cons_len = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
         align_en = ($urandom_range(0, 15) == 0);
         blk_clr  = ($urandom_range(0, 99) == 0);
         @(negedge clk);
      end
      in_vld = 0; cons_en = 0; cons_len = 4'd0; align_en = 0; blk_clr = 0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
